// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), timing-region enum and
// helpers for line/frame totals and region classification.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        REGION_ACTIVE,
        REGION_FP,
        REGION_SYNC,
        REGION_BP
    } region_e;

    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic region_e region_of(input int pos, input int active,
                                          input int fp, input int sync);
        if (pos < active)
            return REGION_ACTIVE;
        else if (pos < active + fp)
            return REGION_FP;
        else if (pos < active + fp + sync)
            return REGION_SYNC;
        else
            return REGION_BP;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth 3-bit shift register with synchronous flush to RST_VAL;
// DEPTH=0 is a plain wire.
module vga_delay_line #(
    parameter int         DEPTH   = 0,
    parameter logic [2:0] RST_VAL = 3'b000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] d_i,
    output logic [2:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = clk_i ^ rst_i;
        assign q_o = d_i;
    end else begin : g_pipe
        logic [2:0] stage_q [DEPTH];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < DEPTH; i++)
                    stage_q[i] <= RST_VAL;
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++)
                    stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator driven by a pixel-enable strobe on the board clock.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int DIV      = 4,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE     = 0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          valid,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] v_cnt,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [2:0]    DEC_RST  = {1'b0, ~HS_POL, ~VS_POL};

    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_cw_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
    end
    if (DIV < 1 || PIPE < 0 || PIPE > 7) begin : g_param_check
        $error("vga_timing_gen: DIV must be >= 1 and PIPE within 0..7");
    end

    logic [DW-1:0] div_q, div_d;
    logic          pix_en_q, pix_en_d;
    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic [2:0]    dec_q, dec_d;
    logic [2:0]    dec_pipe;
    logic          tick;
    region_e       h_region, v_region;

    // Counters advance at the edge that closes a pix_en cycle; decode follows the new values.
    always_comb begin
        tick  = run && pix_en_q;
        div_d = div_q;
        if (run)
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pix_en_d = run && (div_d == DIV_LAST);

        h_d = h_q;
        v_d = v_q;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        line_start_d  = tick && (h_d == '0);
        frame_start_d = line_start_d && (v_d == '0);

        h_region = region_of(int'(h_d), H_ACTIVE, H_FP, H_SYNC);
        v_region = region_of(int'(v_d), V_ACTIVE, V_FP, V_SYNC);
        dec_d    = dec_q;
        if (tick)
            dec_d = {(h_region == REGION_ACTIVE) && (v_region == REGION_ACTIVE),
                     (h_region == REGION_SYNC) ? HS_POL : ~HS_POL,
                     (v_region == REGION_SYNC) ? VS_POL : ~VS_POL};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            pix_en_q      <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            dec_q         <= DEC_RST;
        end else begin
            div_q         <= div_d;
            pix_en_q      <= pix_en_d;
            h_q           <= h_d;
            v_q           <= v_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            dec_q         <= dec_d;
        end
    end

    vga_delay_line #(
        .DEPTH   (PIPE),
        .RST_VAL (DEC_RST)
    ) u_delay (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (dec_q),
        .q_o   (dec_pipe)
    );

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            frame_cnt_q <= '0;
        else if (frame_start_d)
            frame_cnt_q <= frame_cnt_q + 8'd1;
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

    assign pix_en      = pix_en_q;
    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign valid       = dec_pipe[2];
    assign hsync       = dec_pipe[1];
    assign vsync       = dec_pipe[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 14x7 geometry (DIV=2), PIPE=0 and PIPE=3 side by side.
module tb_vga_timing_gen;

    localparam int DIV = 2;
    localparam int HT  = 14;
    localparam int VT  = 7;
    localparam int CW  = 10;
    localparam logic [2:0] DEC_RST = 3'b011;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;

    logic          pix_en0, hsync0, vsync0, valid0, ls0, fs0;
    logic [CW-1:0] h0, v0;
    logic [7:0]    fc0;
    logic          pix_en3, hsync3, vsync3, valid3, ls3, fs3;
    logic [CW-1:0] h3, v3;
    logic [7:0]    fc3;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .DIV(DIV), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(0), .CW(CW)
    ) u_dut0 (
        .clk(clk), .rst(rst), .run(run), .pix_en(pix_en0),
        .hsync(hsync0), .vsync(vsync0), .valid(valid0),
        .h_cnt(h0), .v_cnt(v0), .line_start(ls0), .frame_start(fs0),
        .frame_cnt(fc0)
    );

    vga_timing_gen #(
        .DIV(DIV), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(3), .CW(CW)
    ) u_dut3 (
        .clk(clk), .rst(rst), .run(run), .pix_en(pix_en3),
        .hsync(hsync3), .vsync(vsync3), .valid(valid3),
        .h_cnt(h3), .v_cnt(v3), .line_start(ls3), .frame_start(fs3),
        .frame_cnt(fc3)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         kk = 0;
    int         frames = 0;
    int         ls_seen = 0;
    int         fs_seen = 0;
    logic [2:0] hist [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at k=%0d: got %0h expected %0h", tag, kk, got, exp);
        end
    endtask

    // Closed-form reference: k = running clks since reset release, one pixel every DIV clks.
    function automatic int m_n(input int k);
        return k / DIV;
    endfunction
    function automatic int m_h(input int k);
        return m_n(k) % HT;
    endfunction
    function automatic int m_v(input int k);
        return (m_n(k) / HT) % VT;
    endfunction
    function automatic logic [2:0] m_dec(input int k);
        int h, v;
        if (m_n(k) == 0) return DEC_RST;
        h = m_h(k);
        v = m_v(k);
        return {(h < 8) && (v < 4), !(h == 10 || h == 11), !(v == 5)};
    endfunction
    function automatic logic m_pix(input int k);
        return (k > 0) && (k % DIV == DIV - 1);
    endfunction
    function automatic logic m_ls(input int k);
        return (k > 0) && (k % DIV == 0) && (m_h(k) == 0);
    endfunction
    function automatic logic m_fs(input int k);
        return m_ls(k) && (m_v(k) == 0);
    endfunction

    task automatic step(input logic r, input logic rn);
        logic       moving;
        logic [7:0] e_fc;
        rst = r;
        run = rn;
        @(posedge clk);
        #1;
        moving = 1'b0;
        if (r) begin
            kk = 0;
            frames = 0;
        end else if (rn) begin
            kk++;
            moving = 1'b1;
        end
        for (int i = 3; i > 0; i--)
            hist[i] = r ? DEC_RST : hist[i-1];
        hist[0] = r ? DEC_RST : m_dec(kk);
        if (moving && m_fs(kk)) frames++;
`ifdef VGA_FRAME_CNT_EN
        e_fc = 8'(frames);
`else
        e_fc = 8'd0;
`endif
        if (ls0) ls_seen++;
        if (fs0) fs_seen++;

        check("pix_en0", pix_en0, moving && m_pix(kk));
        check("h_cnt0", h0, m_h(kk));
        check("v_cnt0", v0, m_v(kk));
        check("valid0", valid0, hist[0][2]);
        check("hsync0", hsync0, hist[0][1]);
        check("vsync0", vsync0, hist[0][0]);
        check("line_start0", ls0, moving && m_ls(kk));
        check("frame_start0", fs0, moving && m_fs(kk));
        check("frame_cnt0", fc0, e_fc);
        check("pix_en3", pix_en3, moving && m_pix(kk));
        check("h_cnt3", h3, m_h(kk));
        check("v_cnt3", v3, m_v(kk));
        check("line_start3", ls3, moving && m_ls(kk));
        check("frame_start3", fs3, moving && m_fs(kk));
        check("valid3", valid3, hist[3][2]);
        check("hsync3", hsync3, hist[3][1]);
        check("vsync3", vsync3, hist[3][0]);
        check("frame_cnt3", fc3, e_fc);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) hist[i] = DEC_RST;

        // Power-on reset, then three full frames (3 * 14 * 7 * 2 clks).
        repeat (3) step(1'b1, 1'b1);
        check("reset_hsync", hsync0, 1'b1);
        check("reset_vsync", vsync0, 1'b1);
        ls_seen = 0;
        fs_seen = 0;
        repeat (3 * HT * VT * DIV) step(1'b0, 1'b1);
        check("line_starts_3frames", ls_seen, 21);
        check("frame_starts_3frames", fs_seen, 3);
`ifdef VGA_FRAME_CNT_EN
        check("frame_cnt_after3", fc0, 8'd3);
`else
        check("frame_cnt_after3", fc0, 8'd0);
`endif

        // Reset mid-frame (lands at h=3, v=2).
        repeat (62) step(1'b0, 1'b1);
        check("midframe_h", h0, 3);
        check("midframe_v", v0, 2);
        repeat (3) step(1'b1, 1'b0);
        check("rst_pix_en", pix_en0, 1'b0);
        check("rst_h", h0, 0);
        check("rst_v", v0, 0);
        check("rst_valid", valid0, 1'b0);
        check("rst_hsync", hsync0, 1'b1);
        check("rst_vsync", vsync0, 1'b1);
        check("rst_hsync3", hsync3, 1'b1);
        check("rst_frame_cnt", fc0, 8'd0);
        step(1'b0, 1'b1);
        check("first_pix_en", pix_en0, 1'b1);

        // Freeze at h=5 for five clks, then resume.
        repeat (9) step(1'b0, 1'b1);
        check("freeze_at_h5", h0, 5);
        repeat (5) step(1'b0, 1'b0);
        check("frozen_h", h0, 5);
        check("frozen_pix_en", pix_en0, 1'b0);
        step(1'b0, 1'b1);
        check("resume_pix_en", pix_en0, 1'b1);
        check("resume_h_before", h0, 5);
        step(1'b0, 1'b1);
        check("resume_h6", h0, 6);
        repeat (40) step(1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator, successor to the fixed 640x480 controller plus external clock divisor pair.
- Runs on the board clock and derives an internal pixel-enable strobe, so no separate divided clock domain exists.
- Produces sync, valid, pixel coordinates and line/frame strobes for the pixel generator and board-render logic.
- Geometry, sync polarity, divider ratio and output pipeline depth are all parametrised.

Parameters:
- DIV, 4, board clocks per pixel (100 MHz -> 25 MHz); DIV >= 1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- HS_POL, 0, asserted level of hsync.
- VS_POL, 0, asserted level of vsync.
- PIPE, 0, extra clk delay applied to hsync/vsync/valid (0..7).
- CW, 10, coordinate width.

Ports:
- clk  in  1  board clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  advance enable; low freezes the generator.
- pix_en  out  1  one-clk pixel strobe.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- valid  out  1  pixel is in the active region.
- h_cnt  out  CW  current column.
- v_cnt  out  CW  current line.
- line_start  out  1  pulse when a line wraps.
- frame_start  out  1  pulse when a frame wraps.
- frame_cnt  out  8  frame counter (optional, see below).

Behaviour:
- Reset state at the clk edge with rst=1:
  - div_cnt=0, h_cnt=0, v_cnt=0.
  - pix_en=0, valid=0, line_start=0, frame_start=0, frame_cnt=0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - Every PIPE stage is flushed to these values.
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider:
  - When run=1, div_cnt counts 0..DIV-1 and wraps.
  - pix_en is registered and high for exactly the clk in which div_cnt==DIV-1, so it is high 1 of every DIV clks.
  - With DIV=1, pix_en is high on every clk.
- Counters:
  - On each pix_en, h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 from V_TOTAL-1.
  - h_cnt and v_cnt are registered outputs with zero extra delay.
- Decode, registered and based on the new counter values:
  - valid = (h<H_ACTIVE)&&(v<V_ACTIVE).
  - hsync = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vsync = VS_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL.
  - These three outputs change only in the clk after pix_en.
- Strobes:
  - line_start is a 1-clk pulse in the clk where h_cnt becomes 0.
  - frame_start is a 1-clk pulse in the clk where (h,v) becomes (0,0).
  - Both are coincident with the counter update and are not delayed by PIPE.
- PIPE: hsync, vsync and valid pass through PIPE additional clk registers, aligning them with a downstream pixel pipeline.
- run=0:
  - div_cnt, counters and outputs hold their values; pix_en and strobes are 0.
  - Resuming continues from the exact held state.
- Reset mid-line or mid-frame: the next clk is the reset state. The first pix_en comes DIV clks after rst deasserts (with run=1).
- Widths: h_cnt and v_cnt never exceed TOTAL-1. An elaboration check fails if H_TOTAL or V_TOTAL exceeds 2^CW.

Optional Feature:
- Macro VGA_FRAME_CNT_EN.
- Defined: frame_cnt increments (mod 256) in the clk frame_start pulses, for blink/animation of the cursor and last-move marker.
- Undefined: frame_cnt is tied to 0 and no counter register exists.

Decomposition:
- Package vga_pkg holds:
  - Default 640x480@60 timing constants.
  - A timing-region enum (ACTIVE, FP, SYNC, BP).
  - A helper function computing totals.
- One natural sub-module: vga_delay_line (parametrised depth, width 3, synchronous reset) for the PIPE stages.

Test Plan:
- Small config (H 8/2/2/2, V 4/1/1/1, DIV=2, PIPE=0), 2 frames:
  - pix_en period 2 clks; h_cnt 0..13, v_cnt 0..6.
  - hsync low exactly at h=10,11; valid for h<8 and v<4.
- Reset: rst=1 for 3 clks mid-frame:
  - All outputs at reset values (hsync=1, vsync=1 for POL=0).
  - First pix_en on the 2nd clk after release.
- run toggled low for 5 clks at h=5:
  - Counters hold at 5, pix_en stays 0.
  - Resumes at h=6 on the next pix_en.
- PIPE=3:
  - hsync/valid edges lag the PIPE=0 reference by exactly 3 clks.
  - h_cnt and strobes are unchanged.
- Defaults (DIV=4):
  - One frame lasts 800*525*4 = 1,680,000 clks between frame_start pulses.
  - 525 line_start pulses per frame.
- VGA_FRAME_CNT_EN defined: after 3 frame_start pulses frame_cnt=3. Undefined: frame_cnt stays 0.
